vga_fb_scanout: RTL and testbench

- Parametrised successor to the board's VGA output path: one block with sync timing generator, framebuffer fetch and pixel formatter, runs on the pixel clock.
- Reads 8-bit RGB332 pixels packed four per 32-bit word from RAM port B.
- Adds integer upscaling and a double-buffered framebuffer base that is switched only at frame boundaries.
- Sits between the external pixel-clock PLL and the DAC pins; replaces separate controller and draw modules.

---
 rtl/vga_fb_scanout_if.sv | 31 +++
 rtl/vga_fb_scanout.sv | 194 +++++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_scanout_if.sv
// RAM port B and DAC pin bundle of the VGA scanout block.
// master = scanout core, slave = RAM/board side.
interface vga_fb_scanout_if #(
    parameter int ADDR_W = 17
);
    logic              fb_sel;
    logic [31:0]       q_b;
    logic [ADDR_W-1:0] address_b;
    logic [3:0]        byteena_b;
    logic              hsync;
    logic              vsync;
    logic              sync_b;
    logic              blank_b;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    logic              frame_start;
    logic              cur_buf;

    modport master (
        input  fb_sel, q_b,
        output address_b, byteena_b, hsync, vsync, sync_b, blank_b,
               red, green, blue, frame_start, cur_buf
    );

    modport slave (
        output fb_sel, q_b,
        input  address_b, byteena_b, hsync, vsync, sync_b, blank_b,
               red, green, blue, frame_start, cur_buf
    );
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA scanout: sync timing, RGB332 framebuffer fetch with integer upscale, double-buffered base.
// Latency RAM_LAT+2 on every output; no backpressure. Optional colour-bar generator: VGA_TESTPAT_EN.
module vga_fb_scanout #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYNC   = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYNC   = 2,
    parameter int VBP     = 33,
    parameter int SCALE   = 2,
    parameter int ADDR_W  = 17,
    parameter int BASE0   = 0,
    parameter int BASE1   = 19200,
    parameter int RAM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
`ifdef VGA_TESTPAT_EN
    input  logic test_mode,
`endif
    vga_fb_scanout_if.master bus
);
    localparam int HTOT  = HACTIVE + HFP + HSYNC + HBP;
    localparam int VTOT  = VACTIVE + VFP + VSYNC + VBP;
    localparam int HW    = $clog2(HTOT);
    localparam int VW    = $clog2(VTOT);
    localparam int SH    = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);
    localparam int FB_W  = HACTIVE / SCALE;

    localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(HACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(HACTIVE + HFP);
    localparam logic [HW-1:0] H_SE   = HW'(HACTIVE + HFP + HSYNC);
    localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(VACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(VACTIVE + VFP);
    localparam logic [VW-1:0] V_SE   = VW'(VACTIVE + VFP + VSYNC);
    localparam logic [ADDR_W-1:0] B0 = ADDR_W'(BASE0);
    localparam logic [ADDR_W-1:0] B1 = ADDR_W'(BASE1);

`ifdef VGA_TESTPAT_EN
    localparam int BAR_W = HACTIVE / 8;
`endif

    typedef struct packed {
        logic       vld;
        logic       vis;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       bsel;
        logic [1:0] lane;
`ifdef VGA_TESTPAT_EN
        logic       tp;
        logic [2:0] bar;
`endif
    } meta_t;

    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic              base_sel;
    logic              frame_top;
    logic              sel0;
    logic [HW-1:0]     fx;
    logic [VW-1:0]     fy;
    logic [31:0]       pix_idx;
    logic [ADDR_W-1:0] addr0;
    meta_t             meta0;
    meta_t             pipe [0:RAM_LAT];
    meta_t             mo;
    logic [7:0]        pix;
    logic [23:0]       rgb_nxt;

`ifdef VGA_TESTPAT_EN
    function automatic logic [2:0] bar_color(input logic [2:0] b);
        logic [2:0] c;
        case (b)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // The buffer choice for the top-left pixel must already see fb_sel on its sampling cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            base_sel <= 1'b0;
        else if (frame_top)
            base_sel <= bus.fb_sel;
    end

    always_comb begin
        frame_top = (hcnt == '0) && (vcnt == '0);
        sel0      = frame_top ? bus.fb_sel : base_sel;
        fx        = hcnt >> SH;
        fy        = vcnt >> SH;
        pix_idx   = 32'(fy) * 32'(FB_W) + 32'(fx);
        addr0     = (sel0 ? B1 : B0) + ADDR_W'(pix_idx >> 2);

        meta0      = '0;
        meta0.vld  = 1'b1;
        meta0.vis  = (hcnt < H_VIS) && (vcnt < V_VIS);
        meta0.hs   = !((hcnt >= H_SS) && (hcnt < H_SE));
        meta0.vs   = !((vcnt >= V_SS) && (vcnt < V_SE));
        meta0.fs   = frame_top;
        meta0.bsel = sel0;
        meta0.lane = fx[1:0];
`ifdef VGA_TESTPAT_EN
        meta0.tp   = test_mode;
        meta0.bar  = 3'(32'(hcnt) / BAR_W);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.address_b <= '0;
            for (int i = 0; i <= RAM_LAT; i++) begin
                pipe[i]    <= '0;
                pipe[i].hs <= 1'b1;
                pipe[i].vs <= 1'b1;
            end
        end else begin
            if (meta0.vis)
                bus.address_b <= addr0;
            pipe[0] <= meta0;
            for (int i = 1; i <= RAM_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    // pipe[RAM_LAT] lines up with the q_b returned for the address issued alongside pipe[0].
    always_comb begin
        mo      = pipe[RAM_LAT];
        pix     = bus.q_b[{mo.lane, 3'b000} +: 8];
        rgb_nxt = '0;
        if (mo.vld && mo.vis) begin
`ifdef VGA_TESTPAT_EN
            if (mo.tp)
                rgb_nxt = {{8{bar_color(mo.bar)[2]}}, {8{bar_color(mo.bar)[1]}},
                           {8{bar_color(mo.bar)[0]}}};
            else
`endif
                rgb_nxt = {pix[7:5], pix[7:5], pix[7:6],
                           pix[4:2], pix[4:2], pix[4:3],
                           {4{pix[1:0]}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.sync_b      <= 1'b1;
            bus.blank_b     <= 1'b0;
            bus.red         <= '0;
            bus.green       <= '0;
            bus.blue        <= '0;
            bus.frame_start <= 1'b0;
            bus.cur_buf     <= 1'b0;
        end else begin
            bus.hsync       <= mo.vld ? mo.hs : 1'b1;
            bus.vsync       <= mo.vld ? mo.vs : 1'b1;
            bus.sync_b      <= mo.vld ? (mo.hs & mo.vs) : 1'b1;
            bus.blank_b     <= mo.vld & mo.vis;
            {bus.red, bus.green, bus.blue} <= rgb_nxt;
            bus.frame_start <= mo.vld & mo.fs;
            bus.cur_buf     <= mo.vld ? mo.bsel : bus.cur_buf;
        end
    end

    assign bus.byteena_b = 4'b1111;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout on a reduced 48x23 raster (32x16 visible, SCALE 2, RAM_LAT 1).
module tb_vga_fb_scanout;
    localparam int HA = 32, HF = 4, HS = 8, HB = 4;
    localparam int VA = 16, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int LAT = 3;
    localparam int AW = 8;
    localparam int B1 = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic const_mode = 1'b0;
    int   k = 0;
    int   nvec = 0;
    int   nerr = 0;
`ifdef VGA_TESTPAT_EN
    logic test_mode = 1'b0;
`endif

    vga_fb_scanout_if #(.ADDR_W(AW)) bus ();

    vga_fb_scanout #(
        .HACTIVE(HA), .HFP(HF), .HSYNC(HS), .HBP(HB),
        .VACTIVE(VA), .VFP(VF), .VSYNC(VS), .VBP(VB),
        .SCALE(2), .ADDR_W(AW), .BASE0(0), .BASE1(B1), .RAM_LAT(1)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef VGA_TESTPAT_EN
        .test_mode(test_mode),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // One-cycle RAM: data is the word index, or a fixed lane-test word.
    always @(posedge clk)
        bus.q_b <= const_mode ? 32'hE01C03FF : 32'(bus.address_b);

    wire [23:0] rgb = {bus.red, bus.green, bus.blue};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic run_to_cnt(input string tag, input int target);
        int n = 0;
        while ((k % FR) != target && n < 3 * FR) begin
            step();
            n++;
        end
        chk(tag, 32'((k % FR) == target), 32'd1);
    endtask

    task automatic run_to_out(input string tag, input int target);
        run_to_cnt(tag, (target + LAT) % FR);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hs_cnt = 0, hs_first_k = -1, vs_first = -1, vs_last = -1;
        int vis_cnt = 0, blank_nz = 0, fs_cnt = 0, fs_first_k = -1;
        int sync_err = 0, cb_ones = 0, amax = 0;
        logic [23:0] p00, p08, p09, p0a, p20, p28, pf24;
        logic [AW-1:0] a7, a8, a31, a40, a79, alast;

        bus.fb_sel = 1'b0;
        #12;
        chk("rst_hsync", bus.hsync, 1);
        chk("rst_vsync", bus.vsync, 1);
        chk("rst_sync_b", bus.sync_b, 1);
        chk("rst_blank_b", bus.blank_b, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_frame_start", bus.frame_start, 0);
        chk("rst_cur_buf", bus.cur_buf, 0);
        chk("rst_address", bus.address_b, 0);
        chk("byteena", bus.byteena_b, 4'hF);

        @(negedge clk);
        reset = 1'b0;
        k = 0;

        // First frame, observed cycle by cycle.
        for (int i = 0; i < FR + LAT; i++) begin
            int op, ap;
            step();
            op = k - LAT;
            ap = k - 1;
            if (bus.frame_start) begin
                fs_cnt++;
                if (fs_first_k < 0) fs_first_k = k;
            end
            if (op >= 0 && op < FR) begin
                if (op / HT == 0 && !bus.hsync) begin
                    hs_cnt++;
                    if (hs_first_k < 0) hs_first_k = k;
                end
                if (!bus.vsync) begin
                    if (vs_first < 0) vs_first = op / HT;
                    vs_last = op / HT;
                end
                if (bus.blank_b) vis_cnt++;
                else if (rgb != 0) blank_nz++;
                if (bus.sync_b !== (bus.hsync & bus.vsync)) sync_err++;
                if (bus.cur_buf) cb_ones++;
                if (op == 0)          p00  = rgb;
                if (op == 8)          p08  = rgb;
                if (op == 9)          p09  = rgb;
                if (op == 10)         p0a  = rgb;
                if (op == 2*HT)       p20  = rgb;
                if (op == 2*HT + 8)   p28  = rgb;
                if (op == 15*HT + 24) pf24 = rgb;
            end
            if (ap >= 0 && ap < FR) begin
                if (32'(bus.address_b) > amax) amax = 32'(bus.address_b);
                if (ap == 7)          a7    = bus.address_b;
                if (ap == 8)          a8    = bus.address_b;
                if (ap == 31)         a31   = bus.address_b;
                if (ap == 40)         a40   = bus.address_b;
                if (ap == HT + 31)    a79   = bus.address_b;
                if (ap == 15*HT + 31) alast = bus.address_b;
            end
        end
        chk("hsync_low_cycles", hs_cnt, HS);
        chk("hsync_first_cycle", hs_first_k, HA + HF + LAT);
        chk("vsync_first_line", vs_first, VA + VF);
        chk("vsync_last_line", vs_last, VA + VF + VS - 1);
        chk("visible_cycles", vis_cnt, HA * VA);
        chk("rgb_in_blank", blank_nz, 0);
        chk("sync_b_and", sync_err, 0);
        chk("frame_start_first", fs_first_k, LAT);
        chk("frame_start_count", fs_cnt, 2);
        chk("cur_buf_frame0", cb_ones, 0);
        chk("addr_l0_x7", a7, 0);
        chk("addr_l0_x8", a8, 1);
        chk("addr_l0_x31", a31, 3);
        chk("addr_held_blank", a40, 3);
        chk("addr_l1_x31", a79, 3);
        chk("addr_last_word", alast, 31);
        chk("addr_max", amax, 31);
        chk("pix_0_0", p00, 24'h000000);
        chk("pix_8_0", p08, 24'h000055);
        chk("pix_9_0", p09, 24'h000055);
        chk("pix_10_0", p0a, 24'h000000);
        chk("pix_0_2", p20, 24'h002400);
        chk("pix_8_2", p28, 24'h002455);
        chk("pix_24_15", pf24, 24'h00FFFF);

        // Lane decode with a fixed word.
        const_mode = 1'b1;
        run_to_out("nav_lane0", 3*HT + 0);
        chk("lane0_rgb", rgb, 24'hFFFFFF);
        step();
        chk("lane0_rep_rgb", rgb, 24'hFFFFFF);
        run_to_out("nav_lane1", 3*HT + 2);
        chk("lane1_rgb", rgb, 24'h0000FF);
        run_to_out("nav_lane2", 3*HT + 4);
        chk("lane2_rgb", rgb, 24'h00FF00);
        run_to_out("nav_lane3", 3*HT + 6);
        chk("lane3_rgb", rgb, 24'hFF0000);
        run_to_out("nav_blank", 3*HT + 40);
        chk("blank_rgb", rgb, 0);
        chk("blank_blank_b", bus.blank_b, 0);

        // Mid-frame buffer request waits for the next frame.
        run_to_cnt("nav_mid", 8*HT);
        bus.fb_sel = 1'b1;
        amax = 0;
        cb_ones = 0;
        while ((k % FR) != 0 && amax < 1000) begin
            step();
            if (32'(bus.address_b) > amax) amax = 32'(bus.address_b);
            if (bus.cur_buf) cb_ones++;
        end
        chk("sel_late_addr_max", amax, 31);
        chk("sel_late_cur_buf", cb_ones, 0);
        step();
        chk("buf1_first_addr", bus.address_b, B1);
        step();
        step();
        chk("buf1_frame_start", bus.frame_start, 1);
        chk("buf1_cur_buf", bus.cur_buf, 1);

        // Change on the sampling cycle itself applies to that frame.
        run_to_cnt("nav_top", 0);
        bus.fb_sel = 1'b0;
        step();
        chk("sel_edge_addr", bus.address_b, 0);
        step();
        step();
        chk("sel_edge_cur_buf", bus.cur_buf, 0);

        // Reset mid-frame.
        bus.fb_sel = 1'b1;
        run_to_cnt("nav_rst", 5*HT + 20);
        chk("pre_rst_blank_b", bus.blank_b, 1);
        chk("pre_rst_rgb", rgb, 24'hFFFFFF);
        reset = 1'b1;
        #1;
        chk("mid_rst_hvsync", {bus.hsync, bus.vsync, bus.sync_b}, 3'b111);
        chk("mid_rst_blank_b", bus.blank_b, 0);
        chk("mid_rst_rgb", rgb, 0);
        chk("mid_rst_addr", bus.address_b, 0);
        chk("mid_rst_fs_cb", {bus.frame_start, bus.cur_buf}, 2'b00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        step();
        chk("post_rst_addr", bus.address_b, B1);
        step();
        chk("post_rst_fs_early", bus.frame_start, 0);
        step();
        chk("post_rst_fs", bus.frame_start, 1);
        chk("post_rst_cur_buf", bus.cur_buf, 1);
        chk("post_rst_rgb", rgb, 24'hFFFFFF);

`ifdef VGA_TESTPAT_EN
        test_mode = 1'b1;
        run_to_out("nav_tp0", 2*HT + 0);
        chk("tp_x0", rgb, 24'hFFFFFF);
        run_to_out("nav_tp4", 2*HT + 4);
        chk("tp_x4", rgb, 24'hFFFF00);
        run_to_out("nav_tp8", 2*HT + 8);
        chk("tp_x8", rgb, 24'h00FFFF);
        run_to_out("nav_tp31", 2*HT + 31);
        chk("tp_x31", rgb, 24'h000000);
        run_to_out("nav_tp40", 2*HT + 40);
        chk("tp_blank", rgb, 0);
        test_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
